router_pkt_gen: RTL

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_lfsr8.sv | 36 +++
 rtl/router_pkt_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet generator and its payload LFSR.
package router_pkg;

  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Fibonacci LFSR for payload bytes; a zero seed is replaced by 8'h01 so the
// register never locks up.
module router_lfsr8
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 8'h00) ? LFSR_RESET : seed;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= LFSR_RESET;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/router_pkt_gen.sv
// Packet generator feeding a router: header {len,addr}, LFSR payload, XOR parity.
// Optional parity error injection is enabled by defining ROUTER_PKT_ERR_INJ_EN.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        seed,
  input  logic              corrupt,
  input  logic              busy,
  output logic [7:0]        pkt_data,
  output logic              pkt_valid,
  output logic              gen_busy,
  output logic              done,
  output logic              rej,
  output logic [15:0]       pkt_count
);

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t            state_q, state_d;
  logic [7:0]        gap_q, gap_d;
  logic              done_q, done_d;
  logic              rej_q, rej_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [7:0]        par_q, par_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              corrupt_q, corrupt_d;
  logic              lfsr_load;
  logic              lfsr_adv;
  logic [7:0]        lfsr_val;
  logic              inj;

  router_lfsr8 u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    rej_d     = 1'b0;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    par_d     = par_q;
    rem_d     = rem_q;
    corrupt_d = corrupt_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0 || addr == ADDR_INVALID) begin
            rej_d = 1'b1;
          end else begin
            state_d   = ST_HEADER;
            hdr_d     = {len, addr};
            par_d     = {len, addr};
            rem_d     = len;
            corrupt_d = corrupt;
            lfsr_load = 1'b1;
          end
        end
      end
      ST_HEADER: begin
        if (!busy) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // The LFSR output is the byte on the wire, so it steps only on acceptance.
        if (!busy) begin
          lfsr_adv = 1'b1;
          par_d    = par_q ^ lfsr_val;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          gap_d   = 8'd0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= 8'd0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    hdr_q     <= hdr_d;
    par_q     <= par_d;
    rem_q     <= rem_d;
    corrupt_q <= corrupt_d;
  end

`ifdef ROUTER_PKT_ERR_INJ_EN
  assign inj = corrupt_q;
`else
  // The latched flag stays referenced but can never alter the parity byte.
  assign inj = 1'b0 & corrupt_q;
`endif

  always_comb begin
    pkt_data  = 8'h00;
    pkt_valid = 1'b0;
    unique case (state_q)
      ST_HEADER: begin
        pkt_data  = hdr_q;
        pkt_valid = 1'b1;
      end
      ST_PAYLOAD: begin
        pkt_data  = lfsr_val;
        pkt_valid = 1'b1;
      end
      ST_PARITY: pkt_data = par_q ^ {7'b0, inj};
      default: ;
    endcase
  end

  assign gen_busy  = (state_q != ST_IDLE);
  assign done      = done_q;
  assign rej       = rej_q;
  assign pkt_count = cnt_q;

endmodule
